im_loader: RTL and testbench

- Write-side counterpart of the instruction-fetch path.
- Owns the 4096-word instruction memory and fills it from a byte-serial program stream (length header, then big-endian words).
- Serves the fetch unit's combinational read port.
- Holds the CPU in reset (`cpu_hold`) until a complete program is loaded.

---
 rtl/im_loader_if.sv | 27 ++
 rtl/im_loader.sv | 175 +++++++++++++++++
 tb/tb_im_loader.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// im_loader_if: program-stream, fetch-read and status signals of the
// instruction-memory loader, grouped for connection to im_loader.
// master = the environment (stream source, fetch unit, reset controller);
// slave  = the loader itself.
`timescale 1ns/1ps
interface im_loader_if;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_cmd;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [12:0] words_loaded;

    modport master (
        output start, byte_in, byte_valid, fetch_pc,
        input  byte_ready, fetch_cmd, cpu_hold, load_done, load_err, words_loaded
    );

    modport slave (
        input  start, byte_in, byte_valid, fetch_pc,
        output byte_ready, fetch_cmd, cpu_hold, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/im_loader.sv
// im_loader: owns the instruction memory, fills it from a byte-serial
// program stream (16-bit big-endian word count, then big-endian words)
// and serves the fetch unit's combinational read port. The CPU is held in
// reset until a complete program has been loaded.
//
// Optional build macro IM_INIT_FILE_EN: makes DONE the reset state, so the
// CPU runs straight out of reset.
`timescale 1ns/1ps
module im_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int          DEPTH_LOG2 = 12
) (
    input logic        clk,
    input logic        res,
    im_loader_if.slave bus
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [15:0] MAX_WORD = 16'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

`ifdef IM_INIT_FILE_EN
    localparam state_t RESET_STATE = ST_DONE;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t                 state_q, state_d;
    logic [15:0]            hdr_q, hdr_d;
    logic [23:0]            asm_q, asm_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG2:0]    words_q, words_d;

    logic [31:0]            mem_q [0:DEPTH-1];

    logic                   ready_s;
    logic                   accept_s;
    logic [15:0]            hdr_full_s;
    logic [DEPTH_LOG2:0]    words_inc_s;
    logic                   we_s;
    logic [DEPTH_LOG2-1:0]  waddr_s;
    logic [31:0]            wdata_s;
    logic [DEPTH_LOG2-1:0]  fetch_idx_s;

    // State-dependent handshake and status decode.
    always_comb begin
        ready_s        = 1'b0;
        bus.cpu_hold   = 1'b1;
        bus.load_done  = 1'b0;
        bus.load_err   = 1'b0;
        case (state_q)
            ST_HDR_HI, ST_HDR_LO, ST_DATA: ready_s = 1'b1;
            ST_DONE: begin
                bus.cpu_hold  = 1'b0;
                bus.load_done = 1'b1;
            end
            ST_ERR:  bus.load_err = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    assign bus.byte_ready   = ready_s;
    assign bus.words_loaded = words_q;
    assign accept_s         = bus.byte_valid & ready_s;
    assign hdr_full_s       = {hdr_q[15:8], bus.byte_in};
    assign words_inc_s      = words_q + {{DEPTH_LOG2{1'b0}}, 1'b1};

    // Next-state logic: header capture, word assembly and memory write strobe.
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        we_s    = 1'b0;
        waddr_s = words_q[DEPTH_LOG2-1:0];
        wdata_s = {asm_q, bus.byte_in};
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) begin
                    state_d = ST_HDR_HI;
                    words_d = '0;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HDR_HI: begin
                if (accept_s) begin
                    hdr_d[15:8] = bus.byte_in;
                    state_d     = ST_HDR_LO;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HDR_LO: begin
                if (accept_s) begin
                    hdr_d[7:0] = bus.byte_in;
                    cnt_d      = 2'd0;
                    // A zero count or one larger than the memory cannot be honoured.
                    if ((hdr_full_s == 16'd0) || (hdr_full_s > MAX_WORD)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: asm_d[23:16] = bus.byte_in;
                        2'd1: asm_d[15:8]  = bus.byte_in;
                        2'd2: asm_d[7:0]   = bus.byte_in;
                        2'd3: begin
                            we_s    = 1'b1;
                            words_d = words_inc_s;
                            // Finish on the same edge that writes the last word.
                            if (16'(words_inc_s) == hdr_q) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                        default: asm_d = asm_q;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= RESET_STATE;
            hdr_q   <= 16'd0;
            asm_q   <= 24'd0;
            cnt_q   <= 2'd0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    // Word index of fetch_pc relative to BASE_ADDR. Borrows only travel
    // upward, so subtracting the low bits alone gives the same index as
    // the full 32-bit modular subtraction; higher bits alias.
    assign fetch_idx_s   = bus.fetch_pc[DEPTH_LOG2+1:2] - BASE_ADDR[DEPTH_LOG2+1:2];
    assign bus.fetch_cmd = mem_q[fetch_idx_s];

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: scenario tasks drive the byte stream,
// push expected memory words into a scoreboard queue and drain it through
// the fetch read port once each load has completed.
`timescale 1ns/1ps
module tb_im_loader;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } sb_entry_t;

    logic clk;
    logic res;
    int   vectors;
    int   miscompares;
    sb_entry_t sb[$];

    im_loader_if bus();

    im_loader #(
        .BASE_ADDR  (32'h0000_3000),
        .DEPTH_LOG2 (12)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h55;
    endtask

    task automatic send_word(input logic [31:0] w, input int idx);
        sb_entry_t e;
        e.pc   = 32'h0000_3000 + 32'(idx) * 32'd4;
        e.data = w;
        sb.push_back(e);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
        vectors++;
        if (bus.byte_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0", bus.byte_ready);
        end
        vectors++;
        if (bus.words_loaded !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_words: got %0d want 0", bus.words_loaded);
        end
        vectors++;
        if (bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b want 0", bus.load_err);
        end
`ifdef IM_INIT_FILE_EN
        vectors++;
        if (bus.cpu_hold !== 1'b0 || bus.load_done !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_done: hold=%b done=%b want 0/1", bus.cpu_hold, bus.load_done);
        end
`else
        vectors++;
        if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: hold=%b done=%b want 1/0", bus.cpu_hold, bus.load_done);
        end
`endif
    endtask

    task automatic test_basic_load();
        sb_entry_t e;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h2408_0005, 0);
        // Three bytes of the second word, then hold the last one back.
        send_byte(8'h01);
        send_byte(8'h09);
        send_byte(8'h50);
        vectors++;
        if (bus.load_done !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.words_loaded !== 13'd1) begin
            miscompares++;
            $display("FAIL basic_before_last: done=%b hold=%b words=%0d want 0/1/1",
                     bus.load_done, bus.cpu_hold, bus.words_loaded);
        end
        e.pc = 32'h0000_3004;
        e.data = 32'h0109_5020;
        sb.push_back(e);
        send_byte(8'h20);
        vectors++;
        if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.byte_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: done=%b hold=%b ready=%b want 1/0/0",
                     bus.load_done, bus.cpu_hold, bus.byte_ready);
        end
        vectors++;
        if (bus.words_loaded !== 13'd2) begin
            miscompares++;
            $display("FAIL basic_words: got %0d want 2", bus.words_loaded);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.fetch_pc = e.pc;
            #1;
            vectors++;
            if (bus.fetch_cmd !== e.data) begin
                miscompares++;
                $display("FAIL basic_read pc=%h: got %h want %h", e.pc, bus.fetch_cmd, e.data);
            end
        end
    endtask

    task automatic test_bad_header();
        pulse_start();
        vectors++;
        if (bus.words_loaded !== 13'd0 || bus.byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_clear: words=%0d ready=%b want 0/1", bus.words_loaded, bus.byte_ready);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        vectors++;
        if (bus.load_err !== 1'b1 || bus.byte_ready !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL hdr_zero: err=%b ready=%b hold=%b done=%b want 1/0/1/0",
                     bus.load_err, bus.byte_ready, bus.cpu_hold, bus.load_done);
        end
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h01);
        vectors++;
        if (bus.load_err !== 1'b1 || bus.byte_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hdr_4097: err=%b ready=%b want 1/0", bus.load_err, bus.byte_ready);
        end
    endtask

    task automatic test_backpressure();
        sb_entry_t e;
        logic [7:0] bytes [0:5];
        bytes = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pulse_start();
        e.pc = 32'h0000_3000;
        e.data = 32'hDEAD_BEEF;
        sb.push_back(e);
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[i]);
            if (i == 4) begin
                vectors++;
                if (bus.words_loaded !== 13'd0 || bus.byte_ready !== 1'b1 || bus.load_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gap_midword: words=%0d ready=%b done=%b want 0/1/0",
                             bus.words_loaded, bus.byte_ready, bus.load_done);
                end
            end
            if (i < 5) begin
                tick();
            end
        end
        vectors++;
        if (bus.load_done !== 1'b1 || bus.words_loaded !== 13'd1 || bus.load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_done: done=%b words=%0d err=%b want 1/1/0",
                     bus.load_done, bus.words_loaded, bus.load_err);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.fetch_pc = e.pc;
            #1;
            vectors++;
            if (bus.fetch_cmd !== e.data) begin
                miscompares++;
                $display("FAIL gap_read pc=%h: got %h want %h", e.pc, bus.fetch_cmd, e.data);
            end
        end
    endtask

    task automatic test_full_wrap();
        sb_entry_t e;
        sb_entry_t extra [0:3];
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h00);
        for (int i = 0; i < 4096; i++) begin
            send_word(32'(i), i);
            if (i == 4094) begin
                vectors++;
                if (bus.words_loaded !== 13'd4095 || bus.load_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_penult: words=%0d done=%b want 4095/0", bus.words_loaded, bus.load_done);
                end
            end
        end
        vectors++;
        if (bus.words_loaded !== 13'd4096 || bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done: words=%0d done=%b hold=%b want 4096/1/0",
                     bus.words_loaded, bus.load_done, bus.cpu_hold);
        end
        extra[0].pc = 32'h0000_6FFC; extra[0].data = 32'h0000_0FFF;
        extra[1].pc = 32'h0000_7000; extra[1].data = 32'h0000_0000;
        extra[2].pc = 32'h0000_3007; extra[2].data = 32'h0000_0001;
        extra[3].pc = 32'h0000_2FFC; extra[3].data = 32'h0000_0FFF;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(extra[i]);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.fetch_pc = e.pc;
            #1;
            vectors++;
            if (bus.fetch_cmd !== e.data) begin
                miscompares++;
                $display("FAIL full_read pc=%h: got %h want %h", e.pc, bus.fetch_cmd, e.data);
            end
        end
    endtask

    task automatic test_reset_midload();
        sb_entry_t e;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        send_word(32'hCAFE_0001, 0);
        send_word(32'hCAFE_0002, 1);
        vectors++;
        if (bus.words_loaded !== 13'd2 || bus.cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_progress: words=%0d hold=%b want 2/1", bus.words_loaded, bus.cpu_hold);
        end
        res = 1'b1;
        tick();
        res = 1'b0;
        vectors++;
`ifdef IM_INIT_FILE_EN
        if (bus.words_loaded !== 13'd0 || bus.load_done !== 1'b1 || bus.byte_ready !== 1'b0) begin
`else
        if (bus.words_loaded !== 13'd0 || bus.cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0 || bus.load_done !== 1'b0) begin
`endif
            miscompares++;
            $display("FAIL mid_reset: words=%0d hold=%b ready=%b done=%b",
                     bus.words_loaded, bus.cpu_hold, bus.byte_ready, bus.load_done);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.fetch_pc = e.pc;
            #1;
            vectors++;
            if (bus.fetch_cmd !== e.data) begin
                miscompares++;
                $display("FAIL mid_keep pc=%h: got %h want %h", e.pc, bus.fetch_cmd, e.data);
            end
        end
        // Reload two words; start pulses during DATA must be ignored.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h0BAD_F00D, 0);
        pulse_start();
        vectors++;
        if (bus.words_loaded !== 13'd1 || bus.byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_data: words=%0d ready=%b want 1/1", bus.words_loaded, bus.byte_ready);
        end
        bus.start = 1'b1;
        send_word(32'h1234_5678, 1);
        bus.start = 1'b0;
        vectors++;
        if (bus.words_loaded !== 13'd2 || bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL reload_done: words=%0d done=%b hold=%b want 2/1/0",
                     bus.words_loaded, bus.load_done, bus.cpu_hold);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.fetch_pc = e.pc;
            #1;
            vectors++;
            if (bus.fetch_cmd !== e.data) begin
                miscompares++;
                $display("FAIL reload_read pc=%h: got %h want %h", e.pc, bus.fetch_cmd, e.data);
            end
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        res            = 1'b1;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.fetch_pc   = 32'h0000_3000;
        test_reset();
        test_basic_load();
        test_bad_header();
        test_backpressure();
        test_full_wrap();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
